// File: rtl/uart_pkg.sv
// uart_pkg: shared transmitter state encodings, parity-type constants and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP_A,
        STOP_B
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest legal frame is 9 data bits; narrower data is zero-extended by the caller
    function automatic logic parity_bit(input logic [8:0] d, input logic typ);
        return (^d) ^ (typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period down-counter, tick high on the last cycle of each period
module uart_baud_tick #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         restart,
    input  logic [W-1:0] load,
    output logic         tick
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST)
            cnt <= '0;
        else if (restart)
            cnt <= load;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tick = cnt == '0;

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART frame transmitter with optional parity, 1/2 stop bits and back-to-back frames
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  data_ack,
    output logic                  frame_done
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IW-1:0]         bit_idx;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_q;
    logic                  stop2_q;
    logic                  tick;
    logic                  frame_end;
    logic                  accept;

    assign frame_end  = tick && ((state == STOP_A && !stop2_q) || state == STOP_B);
    assign accept     = Data_Valid && !RST && (state == IDLE || frame_end);
    assign data_ack   = accept;
    assign frame_done = frame_end && !RST;

    // Every tick ends a bit, so the period restarts on every bit boundary and on acceptance
    uart_baud_tick #(.W(PRESCALE_W)) u_tick (
        .CLK     (CLK),
        .RST     (RST),
        .restart (accept || tick),
        .load    (accept ? PRESCALE : prescale_q),
        .tick    (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            TX_OUT     <= 1'b1;
            busy       <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
        end else if (accept) begin
            state      <= START;
            TX_OUT     <= 1'b0;
            busy       <= 1'b1;
            shreg      <= P_DATA;
            bit_idx    <= '0;
            prescale_q <= PRESCALE;
            par_en_q   <= PAR_EN;
            par_q      <= parity_bit(9'(P_DATA), PAR_TYP);
            stop2_q    <= STOP2;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
                START: if (tick) begin
                    state  <= DATA;
                    TX_OUT <= shreg[0];
                    shreg  <= shreg >> 1;
                end
                DATA: if (tick) begin
                    if (bit_idx == LAST) begin
                        state  <= par_en_q ? PARITY : STOP_A;
                        TX_OUT <= par_en_q ? par_q : 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        TX_OUT  <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                PARITY: if (tick) begin
                    state  <= STOP_A;
                    TX_OUT <= 1'b1;
                end
                STOP_A: if (tick) begin
                    state <= stop2_q ? STOP_B : IDLE;
                    busy  <= stop2_q;
                end
                STOP_B: if (tick) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed scenario checks for the UART transmitter (8-bit and 5-bit builds)
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  p_data = '0;
    logic        data_valid = 1'b0;
    logic        par_en = 1'b0;
    logic        par_typ = 1'b0;
    logic        stop2 = 1'b0;
    logic [15:0] prescale = '0;
    logic        tx_out, busy, data_ack, frame_done;

    logic [4:0]  p_data5 = '0;
    logic        data_valid5 = 1'b0;
    logic        tx_out5, busy5, data_ack5, frame_done5;

    int tests = 0;
    int fails = 0;

    logic cap_tx   [1:64];
    logic cap_fd   [1:64];
    logic cap_busy [1:64];
    logic cap_ack  [1:64];

    always #5 clk = ~clk;

    uart_tx_engine dut (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(data_valid),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
        .TX_OUT(tx_out), .busy(busy), .data_ack(data_ack), .frame_done(frame_done)
    );

    uart_tx_engine #(.DATA_WIDTH(5)) dut5 (
        .CLK(clk), .RST(rst), .P_DATA(p_data5), .Data_Valid(data_valid5),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
        .TX_OUT(tx_out5), .busy(busy5), .data_ack(data_ack5), .frame_done(frame_done5)
    );

    task automatic present(input logic [7:0] d, input logic pe, input logic pt,
                           input logic s2, input logic [15:0] ps);
        p_data = d; par_en = pe; par_typ = pt; stop2 = s2; prescale = ps;
        data_valid = 1'b1;
        #1;
    endtask

    task automatic capture(input int n);
        for (int i = 1; i <= n; i++) begin
            cap_tx[i] = tx_out; cap_fd[i] = frame_done; cap_busy[i] = busy; cap_ack[i] = data_ack;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        data_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (tx_out !== 1'b1) begin fails++; $display("FAIL rst_tx got %b exp 1", tx_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
        tests++; if (data_ack !== 1'b0) begin fails++; $display("FAIL rst_ack got %b exp 0", data_ack); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_fd got %b exp 0", frame_done); end
        tests++; if (tx_out5 !== 1'b1 || busy5 !== 1'b0) begin fails++; $display("FAIL rst_dut5 got tx=%b busy=%b exp tx=1 busy=0", tx_out5, busy5); end
        data_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests++; if (tx_out !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL idle_after_rst got tx=%b busy=%b exp tx=1 busy=0", tx_out, busy); end
    endtask

    task automatic test_basic_frame;
        logic [0:9] e = 10'b0101001011;
        present(8'hA5, 1'b0, 1'b0, 1'b0, 16'd3);
        tests++; if (data_ack !== 1'b1) begin fails++; $display("FAIL s1_ack got %b exp 1", data_ack); end
        @(negedge clk);
        #1;
        data_valid = 1'b0;
        capture(40);
        for (int c = 1; c <= 40; c++) begin
            tests++; if (cap_tx[c] !== e[(c-1)/4]) begin fails++; $display("FAIL s1_tx cycle %0d got %b exp %b", c, cap_tx[c], e[(c-1)/4]); end
            tests++; if (cap_fd[c] !== (c == 40)) begin fails++; $display("FAIL s1_fd cycle %0d got %b exp %b", c, cap_fd[c], c == 40); end
            tests++; if (cap_busy[c] !== 1'b1) begin fails++; $display("FAIL s1_busy cycle %0d got %b exp 1", c, cap_busy[c]); end
        end
        tests++; if (busy !== 1'b0 || tx_out !== 1'b1) begin fails++; $display("FAIL s1_end got busy=%b tx=%b exp busy=0 tx=1", busy, tx_out); end
    endtask

    task automatic test_parity;
        for (int t = 0; t < 2; t++) begin
            logic [0:10] e;
            e = (t == 0) ? 11'b01110000011 : 11'b01110000001;
            present(8'h07, 1'b1, t[0], 1'b0, 16'd0);
            tests++; if (data_ack !== 1'b1) begin fails++; $display("FAIL s2_ack typ %0d got %b exp 1", t, data_ack); end
            @(negedge clk);
            #1;
            data_valid = 1'b0;
            capture(11);
            for (int c = 1; c <= 11; c++) begin
                tests++; if (cap_tx[c] !== e[c-1]) begin fails++; $display("FAIL s2_tx typ %0d cycle %0d got %b exp %b", t, c, cap_tx[c], e[c-1]); end
                tests++; if (cap_fd[c] !== (c == 11)) begin fails++; $display("FAIL s2_fd typ %0d cycle %0d got %b exp %b", t, c, cap_fd[c], c == 11); end
            end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL s2_end typ %0d got busy=%b exp 0", t, busy); end
        end
    endtask

    task automatic test_stop2;
        logic [0:11] e = 12'b000111100011;
        present(8'h3C, 1'b1, 1'b0, 1'b1, 16'd0);
        tests++; if (data_ack !== 1'b1) begin fails++; $display("FAIL s3_ack got %b exp 1", data_ack); end
        @(negedge clk);
        #1;
        data_valid = 1'b0;
        capture(12);
        for (int c = 1; c <= 12; c++) begin
            tests++; if (cap_tx[c] !== e[c-1]) begin fails++; $display("FAIL s3_tx cycle %0d got %b exp %b", c, cap_tx[c], e[c-1]); end
            tests++; if (cap_fd[c] !== (c == 12)) begin fails++; $display("FAIL s3_fd cycle %0d got %b exp %b", c, cap_fd[c], c == 12); end
            tests++; if (cap_busy[c] !== 1'b1) begin fails++; $display("FAIL s3_busy cycle %0d got %b exp 1", c, cap_busy[c]); end
        end
        tests++; if (busy !== 1'b0 || tx_out !== 1'b1) begin fails++; $display("FAIL s3_end got busy=%b tx=%b exp busy=0 tx=1", busy, tx_out); end
        stop2 = 1'b0;
        par_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [0:19] e = 20'b01010101010111100001;
        present(8'h55, 1'b0, 1'b0, 1'b0, 16'd1);
        tests++; if (data_ack !== 1'b1) begin fails++; $display("FAIL s4_ack0 got %b exp 1", data_ack); end
        @(negedge clk);
        #1;
        for (int c = 1; c <= 40; c++) begin
            tests++; if (tx_out !== e[(c-1)/2]) begin fails++; $display("FAIL s4_tx cycle %0d got %b exp %b", c, tx_out, e[(c-1)/2]); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL s4_busy cycle %0d got %b exp 1", c, busy); end
            tests++; if (data_ack !== (c == 20)) begin fails++; $display("FAIL s4_ack cycle %0d got %b exp %b", c, data_ack, c == 20); end
            tests++; if (frame_done !== (c == 20 || c == 40)) begin fails++; $display("FAIL s4_fd cycle %0d got %b exp %b", c, frame_done, c == 20 || c == 40); end
            if (c == 1) p_data = 8'h0F;
            if (c == 21) data_valid = 1'b0;
            @(negedge clk);
            #1;
        end
        tests++; if (busy !== 1'b0 || tx_out !== 1'b1) begin fails++; $display("FAIL s4_end got busy=%b tx=%b exp busy=0 tx=1", busy, tx_out); end
    endtask

    task automatic test_reset_mid_frame;
        int k = 0;
        int n_fd = 0;
        present(8'h00, 1'b0, 1'b0, 1'b0, 16'd2);
        @(negedge clk);
        #1;
        data_valid = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        tests++; if (tx_out !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL s5_bit3 got tx=%b busy=%b exp tx=0 busy=1", tx_out, busy); end
        rst = 1'b1;
        data_valid = 1'b1;
        @(negedge clk);
        #1;
        tests++; if (tx_out !== 1'b1) begin fails++; $display("FAIL s5_rst_tx got %b exp 1", tx_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL s5_rst_busy got %b exp 0", busy); end
        tests++; if (data_ack !== 1'b0) begin fails++; $display("FAIL s5_rst_ack got %b exp 0", data_ack); end
        @(negedge clk);
        #1;
        tests++; if (busy !== 1'b0 || tx_out !== 1'b1) begin fails++; $display("FAIL s5_rst_hold got busy=%b tx=%b exp busy=0 tx=1", busy, tx_out); end
        rst = 1'b0;
        #1;
        tests++; if (data_ack !== 1'b1) begin fails++; $display("FAIL s5_reaccept got %b exp 1", data_ack); end
        @(negedge clk);
        #1;
        data_valid = 1'b0;
        tests++; if (tx_out !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL s5_restart got tx=%b busy=%b exp tx=0 busy=1", tx_out, busy); end
        while (busy && k < 64) begin
            n_fd += int'(frame_done);
            @(negedge clk);
            #1;
            k++;
        end
        tests++; if (k != 30) begin fails++; $display("FAIL s5_len got %0d cycles exp 30", k); end
        tests++; if (n_fd != 1) begin fails++; $display("FAIL s5_fd_count got %0d exp 1", n_fd); end
    endtask

    task automatic test_width5;
        logic [0:6] e = 7'b0110011;
        prescale = 16'd1;
        p_data5 = 5'h13;
        data_valid5 = 1'b1;
        #1;
        tests++; if (data_ack5 !== 1'b1) begin fails++; $display("FAIL s6_ack got %b exp 1", data_ack5); end
        @(negedge clk);
        #1;
        data_valid5 = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tests++; if (tx_out5 !== e[(c-1)/2]) begin fails++; $display("FAIL s6_tx cycle %0d got %b exp %b", c, tx_out5, e[(c-1)/2]); end
            tests++; if (frame_done5 !== (c == 14)) begin fails++; $display("FAIL s6_fd cycle %0d got %b exp %b", c, frame_done5, c == 14); end
            @(negedge clk);
            #1;
        end
        tests++; if (busy5 !== 1'b0 || tx_out5 !== 1'b1) begin fails++; $display("FAIL s6_end got busy=%b tx=%b exp busy=0 tx=1", busy5, tx_out5); end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_parity;
        test_stop2;
        test_back_to_back;
        test_reset_mid_frame;
        test_width5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
